// File: rtl/decode_pipe_stage.sv
// Registered instruction-decode stage with load-use stall, flush and stall counter.
// Optional build macro: DECODE_ILLEGAL_TRAP_EN (flag unknown opcode/funct as illegal).
module decode_pipe_stage #(
  parameter int XLEN        = 32,
  parameter int ALU_OP_W    = 4,
  parameter int RA_INDEX    = 31,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_instr,
  input  logic [XLEN-1:0]        in_pc,
  input  logic                   flush,
  input  logic                   ex_load_valid,
  input  logic [4:0]             ex_load_rd,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_pc,
  output logic [4:0]             out_rs,
  output logic [4:0]             out_rt,
  output logic [4:0]             out_rd,
  output logic [4:0]             out_shamt,
  output logic [XLEN-1:0]        out_imm,
  output logic [XLEN-1:0]        out_br_target,
  output logic [XLEN-1:0]        out_j_target,
  output logic                   out_reg_write,
  output logic                   out_mem_read,
  output logic                   out_mem_write,
  output logic                   out_branch,
  output logic                   out_jump,
  output logic                   out_alu_src,
  output logic                   out_mem_to_reg,
  output logic                   out_link,
  output logic [ALU_OP_W-1:0]    out_alu_op,
  output logic                   out_illegal,
  output logic [STALL_CNT_W-1:0] stall_count
);
  localparam logic [ALU_OP_W-1:0] OP_ADD  = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] OP_SUB  = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] OP_AND  = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] OP_OR   = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] OP_XOR  = ALU_OP_W'(4);
  localparam logic [ALU_OP_W-1:0] OP_SLL  = ALU_OP_W'(5);
  localparam logic [ALU_OP_W-1:0] OP_SRL  = ALU_OP_W'(6);
  localparam logic [ALU_OP_W-1:0] OP_SLA  = ALU_OP_W'(7);
  localparam logic [ALU_OP_W-1:0] OP_SRA  = ALU_OP_W'(8);
  localparam logic [ALU_OP_W-1:0] OP_SLT  = ALU_OP_W'(9);
  localparam logic [ALU_OP_W-1:0] OP_MADD = ALU_OP_W'(10);
  localparam logic [ALU_OP_W-1:0] OP_MUL  = ALU_OP_W'(11);
  localparam logic [ALU_OP_W-1:0] OP_NOT  = ALU_OP_W'(12);

  typedef struct packed {
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                branch;
    logic                jump;
    logic                alu_src;
    logic                mem_to_reg;
    logic                link;
    logic [ALU_OP_W-1:0] alu_op;
    logic                illegal;
  } ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs, rt, rd, shamt;
    logic [XLEN-1:0] imm, br_target, j_target;
    ctrl_t           ctrl;
  } slot_t;

  logic [5:0]      opc, funct;
  logic [4:0]      rs, rt, dec_rd;
  logic            reads_rt, hazard, capture;
  logic [XLEN-1:0] pc4, imm;
  ctrl_t           ctrl;
  slot_t           slot_d, slot_q;

  assign opc   = in_instr[31:26];
  assign funct = in_instr[5:0];
  assign rs    = in_instr[25:21];
  assign rt    = in_instr[20:16];

  always_comb begin
    ctrl     = '0;
    reads_rt = 1'b0;
    dec_rd   = in_instr[15:11];
    case (opc)
      6'h00: begin
        reads_rt       = 1'b1;
        ctrl.reg_write = 1'b1;
        case (funct)
          6'h20, 6'h21: ctrl.alu_op = OP_ADD;
          6'h22, 6'h23: ctrl.alu_op = OP_SUB;
          6'h24:        ctrl.alu_op = OP_AND;
          6'h25:        ctrl.alu_op = OP_OR;
          6'h26:        ctrl.alu_op = OP_XOR;
          6'h27:        ctrl.alu_op = OP_NOT;
          6'h00:        ctrl.alu_op = OP_SLL;
          6'h01:        ctrl.alu_op = OP_SLA;
          6'h02:        ctrl.alu_op = OP_SRL;
          6'h03:        ctrl.alu_op = OP_SRA;
          6'h2A:        ctrl.alu_op = OP_SLT;
          6'h18:        ctrl.alu_op = OP_MUL;
          6'h1C:        ctrl.alu_op = OP_MADD;
          default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
            ctrl         = '0;
            ctrl.illegal = 1'b1;
`endif
          end
        endcase
      end
      6'h23: begin // load
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_src    = 1'b1;
        dec_rd          = rt;
      end
      6'h2B: begin // store
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        reads_rt       = 1'b1;
        dec_rd         = rt;
      end
      6'h04, 6'h05: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = OP_SUB;
        reads_rt    = 1'b1;
      end
      6'h02: ctrl.jump = 1'b1;
      6'h03: begin
        ctrl.jump      = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.link      = 1'b1;
        dec_rd         = 5'(RA_INDEX);
      end
      default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
        ctrl.illegal = 1'b1;
`endif
      end
    endcase
  end

  assign pc4 = in_pc + XLEN'(4);
  assign imm = {{(XLEN-16){in_instr[15]}}, in_instr[15:0]};

  always_comb begin
    slot_d           = '0;
    slot_d.pc        = in_pc;
    slot_d.rs        = rs;
    slot_d.rt        = rt;
    slot_d.rd        = dec_rd;
    slot_d.shamt     = in_instr[10:6];
    slot_d.imm       = imm;
    slot_d.br_target = pc4 + (imm << 2);
    slot_d.j_target  = {pc4[XLEN-1:28], in_instr[25:0], 2'b00};
    slot_d.ctrl      = ctrl;
  end

  // rs is always treated as read; rt only for formats that source it.
  assign hazard = in_valid && ex_load_valid && (ex_load_rd != 5'd0) &&
                  ((ex_load_rd == rs) || (reads_rt && ex_load_rd == rt));
  assign in_ready = !flush && !hazard && (!out_valid || out_ready);
  assign capture  = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      slot_q    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid <= 1'b1;
      slot_q    <= slot_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_count <= '0;
    else if (hazard && !flush && stall_count != {STALL_CNT_W{1'b1}})
      stall_count <= stall_count + 1'b1;
  end

  assign out_pc         = slot_q.pc;
  assign out_rs         = slot_q.rs;
  assign out_rt         = slot_q.rt;
  assign out_rd         = slot_q.rd;
  assign out_shamt      = slot_q.shamt;
  assign out_imm        = slot_q.imm;
  assign out_br_target  = slot_q.br_target;
  assign out_j_target   = slot_q.j_target;
  assign out_reg_write  = slot_q.ctrl.reg_write;
  assign out_mem_read   = slot_q.ctrl.mem_read;
  assign out_mem_write  = slot_q.ctrl.mem_write;
  assign out_branch     = slot_q.ctrl.branch;
  assign out_jump       = slot_q.ctrl.jump;
  assign out_alu_src    = slot_q.ctrl.alu_src;
  assign out_mem_to_reg = slot_q.ctrl.mem_to_reg;
  assign out_link       = slot_q.ctrl.link;
  assign out_alu_op     = slot_q.ctrl.alu_op;
  assign out_illegal    = slot_q.ctrl.illegal;
endmodule
